// File: rtl/sync_dr_tx_if.sv
// Link bundle for the sync->async dual-rail transmitter.
// Latency: none (wires only).
// Backpressure: s_valid/s_ready upstream; ack_i completion handshake downstream.
interface sync_dr_tx_if #(
  parameter int WIDTH = 1
);
  // Upstream word handshake
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        s_data;
  // Downstream dual-rail link: out[i][1] is the '1' rail, out[i][0] the '0' rail
  logic                    ack_i;
  logic [WIDTH-1:0][1:0]   out;

  // Environment side: drives words and the downstream ack, observes the link
  modport master (
    output s_valid,
    output s_data,
    output ack_i,
    input  s_ready,
    input  out
  );

  // Transmitter side
  modport slave (
    input  s_valid,
    input  s_data,
    input  ack_i,
    output s_ready,
    output out
  );
endinterface

// File: rtl/sync_dr_tx.sv
// Clocked transmitter driving WIDTH-bit words onto a dual-rail link (ENC "FP" 4-phase RZ or "TP" 2-phase).
// Latency: codeword on out 1 cycle after accept; FP period 2*SYNC_STAGES+3, TP period SYNC_STAGES+2 plus downstream delay.
// Backpressure: s_ready low until the synchronised ack matches the expected idle level in IDLE.
module sync_dr_tx #(
  parameter     ENC         = "TP",
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  sync_dr_tx_if.slave  link
);

  // 4-phase return-to-zero when ENC is "FP", otherwise 2-phase transition signalling
  localparam bit IS_FP = (ENC == "FP");

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for an upstream word
    ST_DATA = 2'd1,  // FP: codeword on the link, waiting for ack high
    ST_NULL = 2'd2,  // FP: spacer on the link, waiting for ack low
    ST_WAIT = 2'd3   // TP: transition sent, waiting for ack to reach the new phase
  } state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [WIDTH-1:0][1:0]   out_q, out_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic                    ack_sync;
  logic                    take;

  // ack_i is asynchronous to clk: it only enters the logic through this flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], link.ack_i};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // Ready only when idle and the downstream has settled at the level matching our phase;
  // a stray ack edge in IDLE therefore just holds s_ready low without changing state.
  assign link.s_ready = (state_q == ST_IDLE) && (ack_sync == phase_q);
  assign take         = link.s_valid && link.s_ready;

  // Rails come straight from flops so the async stage never sees combinational glitches
  assign link.out = out_q;

  // State, phase and rail registers; reset drops the rails to zero in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  // Next-state and next-rail logic; s_data is only looked at on the transfer edge
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (IS_FP) begin
            // One-hot codeword per bit: {rail1, rail0} = {d, ~d}
            for (int i = 0; i < WIDTH; i++) begin
              out_d[i] = {link.s_data[i], ~link.s_data[i]};
            end
            state_d = ST_DATA;
          end else begin
            // Exactly one rail per bit toggles; which rail carries the bit value
            for (int i = 0; i < WIDTH; i++) begin
              if (link.s_data[i]) begin
                out_d[i][1] = ~out_q[i][1];
              end else begin
                out_d[i][0] = ~out_q[i][0];
              end
            end
            phase_d = ~phase_q;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DATA: begin
        // Codeword captured downstream: return to the all-zero spacer
        if (ack_sync) begin
          out_d   = '0;
          state_d = ST_NULL;
        end
      end
      ST_NULL: begin
        // Spacer acknowledged: the link is back at its rest state
        if (!ack_sync) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Downstream has completed the transition we sent
        if (ack_sync == phase_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
